// File: rtl/act_zeroskip_expander_if.sv
// rtl/act_zeroskip_expander_if.sv - stream bundle for the activation zero-skip expander
// Purpose: carries the three handshaked streams of the expander.
// Signals (slave = expander side, master = feeder/consumer side):
//   znz_din   [GROUP_SIZE]  mask, bit i=1 -> element i non-zero
//   znz_vld_i / znz_rdy_o   mask handshake
//   enc_din   [M*DATA_W]    compressed beat, slot 0 in the low bits
//   enc_vld_i / enc_rdy_o   compressed beat handshake
//   act_dout  [M*DATA_W]    dense beat, element 0 in the low bits
//   act_vld_o / act_rdy_i   dense beat handshake
interface act_zeroskip_expander_if #(
  parameter int M          = 8,
  parameter int DATA_W     = 8,
  parameter int GROUP_SIZE = 32
);
  logic [GROUP_SIZE-1:0] znz_din;
  logic                  znz_vld_i;
  logic                  znz_rdy_o;
  logic [M*DATA_W-1:0]   enc_din;
  logic                  enc_vld_i;
  logic                  enc_rdy_o;
  logic [M*DATA_W-1:0]   act_dout;
  logic                  act_vld_o;
  logic                  act_rdy_i;

  modport slave (
    input  znz_din, znz_vld_i, enc_din, enc_vld_i, act_rdy_i,
    output znz_rdy_o, enc_rdy_o, act_dout, act_vld_o
  );

  modport master (
    output znz_din, znz_vld_i, enc_din, enc_vld_i, act_rdy_i,
    input  znz_rdy_o, enc_rdy_o, act_dout, act_vld_o
  );
endinterface

// File: rtl/act_zeroskip_expander.sv
// rtl/act_zeroskip_expander.sv - zero-skip decoder rebuilding dense activation groups
// Purpose: collects a znz mask plus NZ packed compressed slots, scatters the slots
//   to the mask's non-zero positions (zeros elsewhere) and emits the dense group
//   as GROUP_SIZE/M beats.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   group_nz_sel   0: NZ=GROUP_NZ_MAX/2, 1: NZ=GROUP_NZ_MAX
//   bus            act_zeroskip_expander_if.slave (mask, compressed and dense streams)
//   nz_err_o       sticky "mask popcount > NZ" flag
// Optional feature: ZS_EXPANDER_POPCNT_CHECK_EN enables nz_err_o; otherwise it is 0.
module act_zeroskip_expander #(
  parameter int M            = 8,
  parameter int DATA_W       = 8,
  parameter int GROUP_SIZE   = 32,
  parameter int GROUP_NZ_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    group_nz_sel,
  act_zeroskip_expander_if.slave  bus,
  output logic                    nz_err_o
);
  localparam int IW     = $clog2(GROUP_SIZE + 1);
  localparam int SW     = $clog2(M);
  localparam int NZW    = $clog2(GROUP_NZ_MAX);
  localparam int NBEATS = GROUP_SIZE / M;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {GATHER, EXPAND, DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [GROUP_SIZE-1:0]    r_mask;
  logic                     r_mask_held;
  logic [DATA_W-1:0]        r_stage [M];
  logic [IW-1:0]            r_stage_rem;
  logic [DATA_W-1:0]        r_nz [GROUP_NZ_MAX];
  logic [IW-1:0]            r_nz_cnt;
  logic [M*DATA_W-1:0]      r_out [NBEATS];
  logic [BW-1:0]            r_beat;

  logic                     w_in_gather, w_znz_rdy, w_enc_rdy;
  logic                     w_znz_fire, w_enc_fire, w_act_fire;
  logic                     w_gather_done, w_last_beat;
  logic [IW-1:0]            w_nz, w_need, w_avail, w_take;
  logic [SW-1:0]            w_base;
  logic [DATA_W-1:0]        w_src [M];
  logic                     w_nz_we [GROUP_NZ_MAX];
  logic [DATA_W-1:0]        w_nz_wd [GROUP_NZ_MAX];
  logic [IW-1:0]            w_off;
  logic [SW-1:0]            w_src_idx;
  logic [GROUP_SIZE*DATA_W-1:0] w_dense;
  logic [IW-1:0]            w_rank;

  assign w_nz        = group_nz_sel ? IW'(GROUP_NZ_MAX) : IW'(GROUP_NZ_MAX / 2);
  assign w_in_gather = (r_state == GATHER);
  assign w_znz_rdy   = w_in_gather && !r_mask_held;
  // A new beat is only pulled once leftover staged slots are used up.
  assign w_enc_rdy   = w_in_gather && (r_nz_cnt < w_nz) && (r_stage_rem == '0);
  assign w_znz_fire  = w_znz_rdy && bus.znz_vld_i;
  assign w_enc_fire  = w_enc_rdy && bus.enc_vld_i;
  assign w_act_fire  = (r_state == DRAIN) && bus.act_rdy_i;
  assign w_last_beat = (r_beat == BW'(NBEATS - 1));

  // Slot source this cycle: staged leftovers first, else the beat being accepted
  // (bypassing staging so the last handshake can complete the group directly).
  always_comb begin
    w_avail = '0;
    w_base  = '0;
    for (int k = 0; k < M; k++) w_src[k] = r_stage[k];
    if (w_in_gather) begin
      if (r_stage_rem != '0) begin
        w_avail = r_stage_rem;
        w_base  = SW'(IW'(M) - r_stage_rem);
      end else if (w_enc_fire) begin
        w_avail = IW'(M);
        for (int k = 0; k < M; k++) w_src[k] = bus.enc_din[k*DATA_W +: DATA_W];
      end
    end
    w_need = w_nz - r_nz_cnt;
    w_take = (w_avail < w_need) ? w_avail : w_need;
  end

  assign w_gather_done = w_in_gather && (r_mask_held || w_znz_fire) &&
                         ((r_nz_cnt + w_take) == w_nz);

  // nz_reg[j] receives source slot base + (j - collected) when inside this cycle's take window.
  always_comb begin
    w_off     = '0;
    w_src_idx = '0;
    for (int j = 0; j < GROUP_NZ_MAX; j++) begin
      w_off      = IW'(j) - r_nz_cnt;
      w_src_idx  = SW'(IW'(w_base) + w_off);
      w_nz_we[j] = (IW'(j) >= r_nz_cnt) && (w_off < w_take);
      w_nz_wd[j] = w_src[w_src_idx];
    end
  end

  // Scatter: element i takes slot rank(i) = number of set mask bits below i;
  // ranks beyond NZ have no slot and read as zero. Final w_rank is the popcount.
  always_comb begin
    w_dense = '0;
    w_rank  = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (r_mask[i] && (w_rank < w_nz))
        w_dense[i*DATA_W +: DATA_W] = r_nz[w_rank[NZW-1:0]];
      w_rank = w_rank + IW'(r_mask[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= GATHER;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.znz_rdy_o = 1'b0;
    bus.enc_rdy_o = 1'b0;
    bus.act_vld_o = 1'b0;
    bus.act_dout  = '0;
    case (r_state)
      GATHER: begin
        bus.znz_rdy_o = w_znz_rdy;
        bus.enc_rdy_o = w_enc_rdy;
        if (w_gather_done) w_state_nxt = EXPAND;
      end
      EXPAND: w_state_nxt = DRAIN;
      DRAIN: begin
        bus.act_vld_o = 1'b1;
        bus.act_dout  = r_out[r_beat];
        if (bus.act_rdy_i && w_last_beat) w_state_nxt = GATHER;
      end
      default: w_state_nxt = GATHER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= '0;
      r_mask_held <= 1'b0;
      r_stage_rem <= '0;
      r_nz_cnt    <= '0;
      r_beat      <= '0;
      for (int k = 0; k < M; k++) r_stage[k] <= '0;
      for (int j = 0; j < GROUP_NZ_MAX; j++) r_nz[j] <= '0;
      for (int b = 0; b < NBEATS; b++) r_out[b] <= '0;
    end else begin
      if (w_znz_fire) begin
        r_mask      <= bus.znz_din;
        r_mask_held <= 1'b1;
      end
      if (w_in_gather) begin
        r_nz_cnt <= r_nz_cnt + w_take;
        if (r_stage_rem != '0) begin
          r_stage_rem <= r_stage_rem - w_take;
        end else if (w_enc_fire) begin
          r_stage_rem <= IW'(M) - w_take;
          for (int k = 0; k < M; k++) r_stage[k] <= w_src[k];
        end
        for (int j = 0; j < GROUP_NZ_MAX; j++)
          if (w_nz_we[j]) r_nz[j] <= w_nz_wd[j];
      end
      if (r_state == EXPAND) begin
        r_beat <= '0;
        for (int b = 0; b < NBEATS; b++) r_out[b] <= w_dense[b*M*DATA_W +: M*DATA_W];
      end
      if (w_act_fire) begin
        r_beat <= r_beat + BW'(1);
        if (w_last_beat) begin
          r_mask_held <= 1'b0;
          r_nz_cnt    <= '0;
        end
      end
    end
  end

`ifdef ZS_EXPANDER_POPCNT_CHECK_EN
  logic r_nz_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_nz_err <= 1'b0;
    else if ((r_state == EXPAND) && (w_rank > w_nz)) r_nz_err <= 1'b1;
  end
  assign nz_err_o = r_nz_err;
`else
  assign nz_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_act_zeroskip_expander.sv
// tb/tb_act_zeroskip_expander.sv - self-checking bench for act_zeroskip_expander
`timescale 1ns/1ps
module tb_act_zeroskip_expander;
  logic clk = 1'b0;
  logic rst_n;
  logic sel_a, sel_b;
  logic err_a, err_b;

  always #5 clk = ~clk;

  act_zeroskip_expander_if #(.M(8),  .DATA_W(8), .GROUP_SIZE(32)) ifa ();
  act_zeroskip_expander_if #(.M(16), .DATA_W(8), .GROUP_SIZE(32)) ifb ();

  act_zeroskip_expander #(.M(8), .DATA_W(8), .GROUP_SIZE(32), .GROUP_NZ_MAX(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .group_nz_sel(sel_a), .bus(ifa), .nz_err_o(err_a));
  act_zeroskip_expander #(.M(16), .DATA_W(8), .GROUP_SIZE(32), .GROUP_NZ_MAX(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .group_nz_sel(sel_b), .bus(ifb), .nz_err_o(err_b));

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   qa[$];
  logic [7:0]   qb[$];
  logic         exp_err_a, exp_err_b;
  logic [7:0]   exp_el [32];
  logic [127:0] last_beat [4];
  logic [7:0]   slot_ctr;
  int           enc_hs_b = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_znz_rdy(input int d);
    return (d != 0) ? ifb.znz_rdy_o : ifa.znz_rdy_o;
  endfunction
  function automatic logic get_enc_rdy(input int d);
    return (d != 0) ? ifb.enc_rdy_o : ifa.enc_rdy_o;
  endfunction
  function automatic logic get_vld(input int d);
    return (d != 0) ? ifb.act_vld_o : ifa.act_vld_o;
  endfunction
  function automatic logic [127:0] get_dout(input int d);
    return (d != 0) ? ifb.act_dout : {64'b0, ifa.act_dout};
  endfunction

  // enc handshakes of the M=16 instance, counted on the stable half-cycle before the edge
  always @(negedge clk) if (ifb.enc_vld_i && ifb.enc_rdy_o) enc_hs_b++;

  task automatic drive_mask(input int d, input logic [31:0] m, input bit nodelay);
    int n;
    if (!nodelay) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (d != 0) begin ifb.znz_din = m; ifb.znz_vld_i = 1'b1; end
    else        begin ifa.znz_din = m; ifa.znz_vld_i = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!get_znz_rdy(d) && n < 200) begin @(negedge clk); n++; end
    check("znz_handshake", 128'(get_znz_rdy(d)), 128'd1);
    @(posedge clk); #1;
    if (d != 0) ifb.znz_vld_i = 1'b0; else ifa.znz_vld_i = 1'b0;
  endtask

  task automatic drive_enc(input int d, input int nb, input bit seq, input bit nodelay);
    logic [127:0] data;
    logic [7:0]   v;
    int           n;
    int           mm;
    mm = (d != 0) ? 16 : 8;
    for (int b = 0; b < nb; b++) begin
      if (!nodelay) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      data = '0;
      for (int k = 0; k < mm; k++) begin
        if (seq) begin v = slot_ctr; slot_ctr = slot_ctr + 8'd1; end
        else v = 8'($urandom);
        data[k*8 +: 8] = v;
        if (d != 0) qb.push_back(v); else qa.push_back(v);
      end
      if (d != 0) begin ifb.enc_din = data; ifb.enc_vld_i = 1'b1; end
      else        begin ifa.enc_din = data[63:0]; ifa.enc_vld_i = 1'b1; end
      n = 0;
      @(negedge clk);
      while (!get_enc_rdy(d) && n < 200) begin @(negedge clk); n++; end
      check("enc_handshake", 128'(get_enc_rdy(d)), 128'd1);
      @(posedge clk); #1;
      if (d != 0) ifb.enc_vld_i = 1'b0; else ifa.enc_vld_i = 1'b0;
    end
  endtask

  // One full group: feed mask and enough beats, derive the dense group from a slot
  // queue, then drain and compare every beat (optionally stalling beat bp_beat).
  task automatic run_group(input int d, input bit sel, input logic [31:0] mask, input bit seq,
                           input logic [7:0] base, input int bp_beat, input bit nodelay);
    logic [7:0]   slots [16];
    logic [127:0] e;
    int mm, nz, have, nb, rank, n;
    mm   = (d != 0) ? 16 : 8;
    nz   = sel ? 16 : 8;
    have = (d != 0) ? qb.size() : qa.size();
    nb   = (have >= nz) ? 0 : (nz - have + mm - 1) / mm;
    if (d != 0) sel_b = sel; else sel_a = sel;
    slot_ctr = base;
    fork
      drive_mask(d, mask, nodelay);
      drive_enc(d, nb, seq, nodelay);
    join
    for (int k = 0; k < nz; k++) slots[k] = (d != 0) ? qb.pop_front() : qa.pop_front();
    rank = 0;
    for (int i = 0; i < 32; i++) begin
      exp_el[i] = (mask[i] && rank < nz) ? slots[rank] : 8'd0;
      if (mask[i]) rank++;
    end
`ifdef ZS_EXPANDER_POPCNT_CHECK_EN
    if ($countones(mask) > nz) begin
      if (d != 0) exp_err_b = 1'b1; else exp_err_a = 1'b1;
    end
`endif
    if (nodelay) begin
      @(negedge clk); check("latency_expand_vld", 128'(get_vld(d)), 128'd0);
      @(negedge clk); check("latency_drain_vld", 128'(get_vld(d)), 128'd1);
    end
    for (int b = 0; b < 32 / mm; b++) begin
      e = '0;
      for (int k = 0; k < mm; k++) e[k*8 +: 8] = exp_el[b*mm + k];
      n = 0;
      @(negedge clk);
      while (!get_vld(d) && n < 200) begin @(negedge clk); n++; end
      check("act_vld", 128'(get_vld(d)), 128'd1);
      if (b == bp_beat) begin
        repeat (5) begin
          @(negedge clk);
          check("bp_vld", 128'(get_vld(d)), 128'd1);
          check("bp_dout", get_dout(d), e);
          check("bp_znz_rdy", 128'(get_znz_rdy(d)), 128'd0);
        end
      end
      check("act_dout", get_dout(d), e);
      last_beat[b] = get_dout(d);
      if (d != 0) ifb.act_rdy_i = 1'b1; else ifa.act_rdy_i = 1'b1;
      @(posedge clk); #1;
      if (d != 0) ifb.act_rdy_i = 1'b0; else ifa.act_rdy_i = 1'b0;
    end
    check("nz_err", 128'((d != 0) ? err_b : err_a), 128'((d != 0) ? exp_err_b : exp_err_a));
  endtask

  function automatic logic [31:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom & $urandom & $urandom;
      2:       return 32'hFF << $urandom_range(0, 24);
      default: return (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h0, n;
    rst_n = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    exp_err_a = 1'b0; exp_err_b = 1'b0;
    ifa.znz_din = '0; ifa.znz_vld_i = 1'b0; ifa.enc_din = '0; ifa.enc_vld_i = 1'b0; ifa.act_rdy_i = 1'b0;
    ifb.znz_din = '0; ifb.znz_vld_i = 1'b0; ifb.enc_din = '0; ifb.enc_vld_i = 1'b0; ifb.act_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_act_vld_a", 128'(ifa.act_vld_o), 128'd0);
    check("rst_act_dout_a", 128'(ifa.act_dout), 128'd0);
    check("rst_nz_err_a", 128'(err_a), 128'd0);
    check("rst_act_vld_b", 128'(ifb.act_vld_o), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_znz_rdy", 128'(ifa.znz_rdy_o), 128'd1);
    check("idle_enc_rdy", 128'(ifa.enc_rdy_o), 128'd1);

    run_group(0, 1'b0, 32'h0000_00FF, 1'b1, 8'd1, -1, 1'b1);
    check("t1_beat0", last_beat[0], 128'h0807_0605_0403_0201);
    check("t1_beat3", last_beat[3], 128'd0);

    run_group(0, 1'b0, 32'h8000_0001, 1'b1, 8'h0A, -1, 1'b0);
    check("t2_beat0", last_beat[0], 128'h0A);
    check("t2_beat3", last_beat[3], 128'h0B00_0000_0000_0000);

    run_group(0, 1'b1, 32'hFFFF_0000, 1'b1, 8'd1, -1, 1'b0);
    check("t3_beat1", last_beat[1], 128'd0);
    check("t3_beat2", last_beat[2], 128'h0807_0605_0403_0201);
    check("t3_beat3", last_beat[3], 128'h100F_0E0D_0C0B_0A09);

    run_group(0, 1'b0, 32'h0F0F_00FF, 1'b0, 8'd0, 1, 1'b0);

    h0 = enc_hs_b;
    run_group(1, 1'b0, 32'h0000_00FF, 1'b1, 8'd1, -1, 1'b0);
    check("t4_g0_beat0", last_beat[0], 128'h0807_0605_0403_0201);
    run_group(1, 1'b0, 32'hFF00_0000, 1'b1, 8'd1, -1, 1'b0);
    check("t4_g1_beat1", last_beat[1], {64'h100F_0E0D_0C0B_0A09, 64'h0});
    check("t4_enc_handshakes", 128'(enc_hs_b - h0), 128'd1);

    run_group(0, 1'b0, 32'h0000_03FF, 1'b1, 8'd1, -1, 1'b0);
    check("t6_beat1", last_beat[1], 128'd0);
`ifdef ZS_EXPANDER_POPCNT_CHECK_EN
    check("t6_err_set", 128'(err_a), 128'd1);
`else
    check("t6_err_tied", 128'(err_a), 128'd0);
`endif
    run_group(0, 1'b0, 32'h0000_0011, 1'b0, 8'd0, -1, 1'b0);

    for (int g = 0; g < 40; g++)
      run_group($urandom_range(0, 1), 1'($urandom), rand_mask(), 1'b0, 8'd0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : -1, 1'b0);

    sel_a = 1'b0;
    fork
      drive_mask(0, 32'hFFFF_FFFF, 1'b0);
      drive_enc(0, 1, 1'b0, 1'b0);
    join
    n = 0;
    @(negedge clk);
    while (!ifa.act_vld_o && n < 200) begin @(negedge clk); n++; end
    check("rstd_vld_before", 128'(ifa.act_vld_o), 128'd1);
`ifdef ZS_EXPANDER_POPCNT_CHECK_EN
    check("rstd_err_before", 128'(err_a), 128'd1);
`endif
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstd_act_vld", 128'(ifa.act_vld_o), 128'd0);
    check("rstd_act_dout", 128'(ifa.act_dout), 128'd0);
    check("rstd_nz_err_a", 128'(err_a), 128'd0);
    check("rstd_nz_err_b", 128'(err_b), 128'd0);
    qa.delete(); qb.delete();
    exp_err_a = 1'b0; exp_err_b = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_group(0, 1'b1, rand_mask(), 1'b0, 8'd0, -1, 1'b0);
    run_group(1, 1'b0, rand_mask(), 1'b0, 8'd0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
